// File: rtl/mir_pkg.sv
// Shared definitions for the format-1 micro-instruction sequencer:
// opcode values, ALU/shifter control codes, op-class and FSM state encodings.
package mir_pkg;

  // Format-1 opcodes (low 10 bits of the opcode field).
  localparam logic [9:0] OP_AND = 10'h000;
  localparam logic [9:0] OP_OR  = 10'h001;
  localparam logic [9:0] OP_ADC = 10'h002;
  localparam logic [9:0] OP_ADD = 10'h003;
  localparam logic [9:0] OP_MOV = 10'h004;
  localparam logic [9:0] OP_CPL = 10'h005;
  localparam logic [9:0] OP_STR = 10'h006;
  localparam logic [9:0] OP_LDR = 10'h007;
  localparam logic [9:0] OP_CLC = 10'h008;
  localparam logic [9:0] OP_STC = 10'h009;
  localparam logic [9:0] OP_RET = 10'h00A;
  localparam logic [9:0] OP_VGP = 10'h00B;
  localparam logic [9:0] OP_VGF = 10'h00C;

  // ALU control codes.
  localparam logic [3:0] ALUC_AND = 4'b0111;
  localparam logic [3:0] ALUC_OR  = 4'b0110;
  localparam logic [3:0] ALUC_ADC = 4'b0101;
  localparam logic [3:0] ALUC_ADD = 4'b0100;
  localparam logic [3:0] ALUC_MOV = 4'b0001;
  localparam logic [3:0] ALUC_CPL = 4'b0011;
  localparam logic [3:0] ALUC_CLC = 4'b1011;
  localparam logic [3:0] ALUC_STC = 4'b1100;
  localparam logic [3:0] ALUC_NOP = 4'b1111;

  // Shifter control codes.
  localparam logic [2:0] SH_PASS = 3'b000;
  localparam logic [2:0] SH_NOP  = 3'b111;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsMemRd,
    ClsMemWr,
    ClsVgaP,
    ClsVgaF,
    ClsIllegal
  } op_class_e;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMemWait,
    StVgaWait,
    StVgaFire,
    StDone
  } mir_state_e;

endpackage

// File: rtl/mir_f1_decode.sv
// Combinational format-1 opcode decoder.
// Ports:
//   opcode_i  opcode to decode (bits above [9:0] must be zero, else illegal)
//   cls_o     operation class
//   aluc_o    ALU control (all ones = NOP)
//   sh_o      shifter control (all ones = NOP)
module mir_f1_decode
  import mir_pkg::*;
#(
  parameter int unsigned OPCODE_W = 10,
  parameter int unsigned ALUC_W   = 4,
  parameter int unsigned SH_W     = 3
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output op_class_e           cls_o,
  output logic [ALUC_W-1:0]   aluc_o,
  output logic [SH_W-1:0]     sh_o
);

  logic       upper_zero;
  logic [9:0] op_lo;

  assign upper_zero = ((opcode_i >> 10) == '0);
  assign op_lo      = opcode_i[9:0];

  always_comb begin
    cls_o  = ClsIllegal;
    aluc_o = '1;
    sh_o   = '1;
    if (upper_zero) begin
      case (op_lo)
        OP_AND: begin cls_o = ClsAlu; aluc_o = ALUC_W'(ALUC_AND); sh_o = SH_W'(SH_PASS); end
        OP_OR:  begin cls_o = ClsAlu; aluc_o = ALUC_W'(ALUC_OR);  sh_o = SH_W'(SH_PASS); end
        OP_ADC: begin cls_o = ClsAlu; aluc_o = ALUC_W'(ALUC_ADC); sh_o = SH_W'(SH_PASS); end
        OP_ADD: begin cls_o = ClsAlu; aluc_o = ALUC_W'(ALUC_ADD); sh_o = SH_W'(SH_PASS); end
        OP_MOV: begin cls_o = ClsAlu; aluc_o = ALUC_W'(ALUC_MOV); sh_o = SH_W'(SH_PASS); end
        OP_CPL: begin cls_o = ClsAlu; aluc_o = ALUC_W'(ALUC_CPL); sh_o = SH_W'(SH_PASS); end
        // Flag ops leave the shifter idle.
        OP_CLC: begin cls_o = ClsAlu; aluc_o = ALUC_W'(ALUC_CLC); end
        OP_STC: begin cls_o = ClsAlu; aluc_o = ALUC_W'(ALUC_STC); end
        // RET occupies an EXEC slot with NOP controls.
        OP_RET: cls_o = ClsAlu;
        OP_STR: cls_o = ClsMemWr;
        OP_LDR: cls_o = ClsMemRd;
        OP_VGP: cls_o = ClsVgaP;
        OP_VGF: cls_o = ClsVgaF;
        default: cls_o = ClsIllegal;
      endcase
    end
  end

endmodule

// File: rtl/mir_sequencer.sv
// Clocked format-1 micro-instruction sequencer. Accepts one opcode per start pulse
// when idle, drives registered ALU/shifter controls, and runs memory (req/ack with
// timeout) and VGA (ready handshake) operations, retiring each with a done pulse.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        opcode valid, accepted only while busy=0
//   opcode       instruction opcode
//   mem_ack      memory completed current read/write
//   vga_ready    VGA controller can take print/flip
//   aluc, sh     ALU/shifter controls (all ones = NOP)
//   read, write  memory request levels
//   flip, print  VGA 1-cycle pulses
//   busy         high outside IDLE
//   done, err    retire pulse and its error flag
module mir_sequencer
  import mir_pkg::*;
#(
  parameter int unsigned OPCODE_W = 10,
  parameter int unsigned ALUC_W   = 4,
  parameter int unsigned SH_W     = 3,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned TO_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ack,
  input  logic                vga_ready,
  output logic [ALUC_W-1:0]   aluc,
  output logic [SH_W-1:0]     sh,
  output logic                read,
  output logic                write,
  output logic                flip,
  output logic                print,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [ALUC_W-1:0] AlucNop = '1;
  localparam logic [SH_W-1:0]   ShNop   = '1;
  localparam logic [TO_W-1:0]   CntLast = TO_W'(TIMEOUT - 1);

  op_class_e         dec_cls;
  logic [ALUC_W-1:0] dec_aluc;
  logic [SH_W-1:0]   dec_sh;

  mir_f1_decode #(
    .OPCODE_W(OPCODE_W),
    .ALUC_W  (ALUC_W),
    .SH_W    (SH_W)
  ) u_decode (
    .opcode_i(opcode),
    .cls_o   (dec_cls),
    .aluc_o  (dec_aluc),
    .sh_o    (dec_sh)
  );

  mir_state_e        state_q;
  op_class_e         cls_q;
  logic [TO_W-1:0]   cnt_q;
  logic [ALUC_W-1:0] aluc_q;
  logic [SH_W-1:0]   sh_q;
  logic              read_q, write_q, flip_q, print_q, busy_q, done_q, err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cls_q   <= ClsIllegal;
      cnt_q   <= '0;
      aluc_q  <= AlucNop;
      sh_q    <= ShNop;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      flip_q  <= 1'b0;
      print_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Controls and pulses default to idle; states below override for one cycle.
      aluc_q  <= AlucNop;
      sh_q    <= ShNop;
      flip_q  <= 1'b0;
      print_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cls_q  <= dec_cls;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            case (dec_cls)
              ClsAlu: begin
                state_q <= StExec;
                aluc_q  <= dec_aluc;
                sh_q    <= dec_sh;
              end
              ClsMemRd: begin
                state_q <= StMemWait;
                read_q  <= 1'b1;
              end
              ClsMemWr: begin
                state_q <= StMemWait;
                write_q <= 1'b1;
              end
              ClsVgaP, ClsVgaF: state_q <= StVgaWait;
              default: begin
                state_q <= StDone;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end
            endcase
          end
        end
        StExec: begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StMemWait: begin
          // Ack wins over timeout when both land in the last allowed cycle.
          if (mem_ack || (cnt_q == CntLast)) begin
            state_q <= StDone;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= ~mem_ack;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StVgaWait: begin
          if (vga_ready) begin
            state_q <= StVgaFire;
            print_q <= (cls_q == ClsVgaP);
            flip_q  <= (cls_q == ClsVgaF);
          end
        end
        StVgaFire: begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign aluc  = aluc_q;
  assign sh    = sh_q;
  assign read  = read_q;
  assign write = write_q;
  assign flip  = flip_q;
  assign print = print_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mir_sequencer.sv
// Directed self-checking bench for mir_sequencer.
module tb_mir_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] opcode = '0;
  logic       mem_ack = 1'b0;
  logic       vga_ready = 1'b0;
  logic [3:0] aluc;
  logic [2:0] sh;
  logic       read, write, flip, print, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  mir_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opcode   (opcode),
    .mem_ack  (mem_ack),
    .vga_ready(vga_ready),
    .aluc     (aluc),
    .sh       (sh),
    .read     (read),
    .write    (write),
    .flip     (flip),
    .print    (print),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed {read,write,flip,print,busy,done,err}.
  function automatic logic [6:0] flags();
    return {read, write, flip, print, busy, done, err};
  endfunction

  // ALU/flag/RET opcode table with hand-derived controls.
  logic [9:0] alu_op   [9] = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h004,
                               10'h005, 10'h008, 10'h009, 10'h00A};
  logic [3:0] alu_aluc [9] = '{4'b0111, 4'b0110, 4'b0101, 4'b0100, 4'b0001,
                               4'b0011, 4'b1011, 4'b1100, 4'b1111};
  logic [2:0] alu_sh   [9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                               3'b000, 3'b111, 3'b111, 3'b111};

  initial begin
    int n;
    // Reset state
    #12;
    check("rst_aluc", 32'(aluc), 32'hF);
    check("rst_sh", 32'(sh), 32'h7);
    check("rst_flags", 32'(flags()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: ADD
    start = 1'b1; opcode = 10'h003;
    tick();
    start = 1'b0;
    check("add_aluc", 32'(aluc), 32'h4);
    check("add_sh", 32'(sh), 32'h0);
    check("add_c1_flags", 32'(flags()), 32'b0000100);
    tick();
    check("add_c2_flags", 32'(flags()), 32'b0000110);
    check("add_c2_aluc", 32'(aluc), 32'hF);
    tick();
    check("add_c3_flags", 32'(flags()), 32'b0000000);

    // ALU table sweep
    for (int i = 0; i < 9; i++) begin
      start = 1'b1; opcode = alu_op[i];
      tick();
      start = 1'b0;
      check($sformatf("tbl_aluc_%0h", alu_op[i]), 32'(aluc), 32'(alu_aluc[i]));
      check($sformatf("tbl_sh_%0h", alu_op[i]), 32'(sh), 32'(alu_sh[i]));
      tick();
      check($sformatf("tbl_done_%0h", alu_op[i]), 32'(flags()), 32'b0000110);
      tick();
    end

    // 2: LDR with ack on 3rd wait cycle
    start = 1'b1; opcode = 10'h007;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ldr_wait%0d", i), 32'(flags()), 32'b1000100);
      if (i == 2) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    check("ldr_done", 32'(flags()), 32'b0000110);
    tick();
    check("ldr_idle", 32'(flags()), 32'b0000000);

    // LDR with ack already high in the first wait cycle
    mem_ack = 1'b1; start = 1'b1; opcode = 10'h007;
    tick();
    start = 1'b0;
    check("ldr1_wait", 32'(flags()), 32'b1000100);
    tick();
    mem_ack = 1'b0;
    check("ldr1_done", 32'(flags()), 32'b0000110);
    tick();

    // 3: STR timeout
    start = 1'b1; opcode = 10'h006;
    tick();
    start = 1'b0;
    n = 0;
    while (write && n < 40) begin
      n++;
      tick();
    end
    check("str_write_cycles", 32'(n), 32'd15);
    check("str_timeout_done", 32'(flags()), 32'b0000111);
    tick();
    check("str_idle", 32'(flags()), 32'b0000000);

    // 4: VGP with vga_ready low for 5 cycles
    start = 1'b1; opcode = 10'h00B;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("vgp_wait%0d", i), 32'(flags()), 32'b0000100);
      tick();
    end
    vga_ready = 1'b1;
    tick();
    vga_ready = 1'b0;
    check("vgp_fire", 32'(flags()), 32'b0001100);
    tick();
    check("vgp_done", 32'(flags()), 32'b0000110);
    tick();

    // VGF with vga_ready already high
    vga_ready = 1'b1; start = 1'b1; opcode = 10'h00C;
    tick();
    start = 1'b0;
    check("vgf_wait", 32'(flags()), 32'b0000100);
    tick();
    vga_ready = 1'b0;
    check("vgf_fire", 32'(flags()), 32'b0010100);
    tick();
    check("vgf_done", 32'(flags()), 32'b0000110);
    tick();

    // 5: illegal opcode, second start while busy ignored
    start = 1'b1; opcode = 10'h0FF;
    tick();
    opcode = 10'h003;
    check("ill_flags", 32'(flags()), 32'b0000111);
    check("ill_aluc", 32'(aluc), 32'hF);
    check("ill_sh", 32'(sh), 32'h7);
    tick();
    start = 1'b0;
    check("ill_ignored_flags", 32'(flags()), 32'b0000000);
    check("ill_ignored_aluc", 32'(aluc), 32'hF);
    tick();
    check("ill_still_idle", 32'(flags()), 32'b0000000);

    // 6: async reset during MEM_WAIT
    start = 1'b1; opcode = 10'h007;
    tick();
    start = 1'b0;
    check("rstm_wait", 32'(flags()), 32'b1000100);
    #2 rst_n = 1'b0;
    #1;
    check("rstm_async", 32'(flags()), 32'b0000000);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rstm_nodone%0d", i), 32'(flags()), 32'b0000000);
    end
    start = 1'b1; opcode = 10'h000;
    tick();
    start = 1'b0;
    check("rstm_and_aluc", 32'(aluc), 32'h7);
    check("rstm_and_sh", 32'(sh), 32'h0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
